datapath_sequencer: RTL
=======================

// Module: datapath_sequencer
// PURPOSE
//  Moore-FSM controller for the simple RISC datapath (register file, A/B/C regs, shifter, ALU, status).
//  Sits between the instruction decoder and the datapath. Owns loada/loadb/loadc/loads/asel/bsel/vsel/nsel/write.
//  Runs one instruction per start pulse s, raises w when idle, and counts completed instructions.
// PARAMETERS
//  CNT_W   16   width of the retired-instruction counter (wraps modulo 2^CNT_W)
// PORTS
//  clk        in   1      rising-edge clock; single clock domain
//  reset      in   1      synchronous reset, active-low: sampled on clk rising edge, asserted when 0
//  s          in   1      start; sampled only in WAIT
//  opcode     in   3      decoder opcode field
//  op         in   2      decoder op field
//  w          out  1      1 only in WAIT (ready for next instruction)
//  loada      out  1      load A register
//  loadb      out  1      load B register
//  loadc      out  1      load C register
//  loads      out  1      load status flags N/V/Z
//  asel       out  1      1 = ALU A input forced to 0
//  bsel       out  1      1 = ALU B input is sximm5 (always 0 in this ISA subset)
//  vsel       out  2      writeback source: 00 = C, 10 = sximm8 (01, 11 reserved, never driven)
//  nsel       out  2      register select: 00 = Rn, 01 = Rd, 10 = Rm
//  write      out  1      register-file write enable
//  illegal    out  1      sticky: last started instruction was unsupported; cleared on next accepted s
//  insn_count out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  Reset: state = WAIT, insn_count = 0, illegal = 0, latched opcode/op = 0.
//   Outputs after reset: w = 1, all others 0.
//  Reset mid-instruction: next edge returns to WAIT. write is not asserted after that edge. No partial retire.
//  Handshake: in WAIT with s = 1 at an edge, latch {opcode, op} internally, clear illegal, go to DECODE.
//   s is ignored in every other state. Inputs may change freely after the accepting edge.
//  States (3-bit encoding): WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM.
//  DECODE branches on the latched {opcode, op}:
//   110/10 MOV Rn,#imm8  -> WR_IMM
//   110/00 MOV Rd,Rm     -> GET_B
//   101/11 MVN           -> GET_B
//   101/00 ADD, 101/01 CMP, 101/10 AND -> GET_A
//   any other code       -> WAIT, with illegal <= 1
//  GET_A -> GET_B always.
//  GET_B -> EXEC always.
//  EXEC -> WAIT if CMP, else WR_REG.
//  WR_REG -> WAIT. WR_IMM -> WAIT.
//  Per-state outputs; anything not listed is 0:
//   WAIT:   w = 1
//   GET_A:  nsel = 00, loada = 1
//   GET_B:  nsel = 10, loadb = 1
//   EXEC:   loadc = 1; asel = 1 for MOV-reg and MVN; loads = 1 only for CMP
//   WR_REG: nsel = 01, vsel = 00, write = 1
//   WR_IMM: nsel = 00, vsel = 10, write = 1
//  Outputs are pure decode of the state plus latched op; no combinational path from s, opcode or op.
//  Latency, counted in edges from the accepting edge to w = 1 again:
//   MOV imm = 3, MOV reg = 5, MVN = 5, ADD = 6, AND = 6, CMP = 5, illegal = 2.
//  insn_count increments by 1 on the edge leaving WR_IMM, WR_REG, or EXEC (CMP only).
//   Wraps from all-ones to 0. Illegal codes do not count.
//  write and loads are never both 1. write is never 1 in WAIT or DECODE.
// STRUCTURE
//  Shared package rsm_pkg: state localparams, opcode/op constants (OPC_MOV = 3'b110, OPC_ALU = 3'b101,
//   OP_ADD, OP_CMP, OP_AND, OP_MVN), and NSEL_* / VSEL_* encodings. The decoder and datapath use these too.
//  One flat module: a state register, a next-state case, an output case and the latched op register.
//  insn_count is a plain counter kept inline; no sub-module.
// TESTING
//  1. reset = 0 for 2 edges -> w = 1, all loads/write = 0, insn_count = 0, illegal = 0.
//  2. s = 1 with {110,10} -> WR_IMM on edge 2 with write = 1, vsel = 10, nsel = 00;
//     w = 1 after edge 3; insn_count = 1.
//  3. ADD {101,00} -> loada (nsel 00), loadb (nsel 10), loadc (loads 0), then write (nsel 01, vsel 00)
//     on consecutive cycles; w after edge 6.
//  4. CMP {101,01} -> EXEC has loads = 1 and loadc = 1; write never asserted; w after edge 5; count + 1.
//  5. MVN {101,11} and MOV reg {110,00} -> GET_A skipped, asel = 1 in EXEC, w after edge 5.
//  6. {111,00} -> illegal = 1 after edge 2, count unchanged; next valid s clears it.
//     Also: reset = 0 in GET_B -> WAIT next edge, no write.
//     Also: preload count to 2^CNT_W - 1 via retires -> wraps to 0.

Source files
------------

// File: rtl/rsm_pkg.sv
// Shared encodings for the RISC datapath: sequencer states, decoder opcode/op
// constants and the nsel/vsel selector codes used by decoder, datapath and sequencer.
package rsm_pkg;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_GET_A  = 3'd2,
    ST_GET_B  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WR_REG = 3'd5,
    ST_WR_IMM = 3'd6
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RM = 2'b10;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
  } insn_t;

  function automatic logic is_cmp(insn_t i);
    return (i.opcode == OPC_ALU) && (i.op == OP_CMP);
  endfunction

  // MOV-reg and MVN pass B through the ALU with A forced to zero.
  function automatic logic is_b_only(insn_t i);
    return ((i.opcode == OPC_MOV) && (i.op == OP_MOV_REG)) ||
           ((i.opcode == OPC_ALU) && (i.op == OP_MVN));
  endfunction

endpackage

// File: rtl/datapath_sequencer.sv
// Moore controller for the RISC datapath: one instruction per start pulse, w high when idle.
// Outputs decode only from state and the latched instruction; retired instructions are counted.
module datapath_sequencer
  import rsm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic [2:0]       opcode,
  input  logic [1:0]       op,
  output logic             w,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       vsel,
  output logic [1:0]       nsel,
  output logic             write,
  output logic             illegal,
  output logic [CNT_W-1:0] insn_count
);

  state_e           state_q, state_d;
  insn_t            insn_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             set_illegal;
  logic             accept;

  assign accept = (state_q == ST_WAIT) && s;

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    case (state_q)
      ST_WAIT:   if (s) state_d = ST_DECODE;
      ST_DECODE: begin
        case (insn_q)
          {OPC_MOV, OP_MOV_IMM}: state_d = ST_WR_IMM;
          {OPC_MOV, OP_MOV_REG}: state_d = ST_GET_B;
          {OPC_ALU, OP_MVN}:     state_d = ST_GET_B;
          {OPC_ALU, OP_ADD},
          {OPC_ALU, OP_CMP},
          {OPC_ALU, OP_AND}:     state_d = ST_GET_A;
          default: begin
            state_d     = ST_WAIT;
            set_illegal = 1'b1;
          end
        endcase
      end
      ST_GET_A:  state_d = ST_GET_B;
      ST_GET_B:  state_d = ST_EXEC;
      ST_EXEC: begin
        if (is_cmp(insn_q)) begin
          state_d = ST_WAIT;
          retire  = 1'b1;
        end else begin
          state_d = ST_WR_REG;
        end
      end
      ST_WR_REG, ST_WR_IMM: begin
        state_d = ST_WAIT;
        retire  = 1'b1;
      end
      default:   state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_WAIT;
      insn_q    <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        insn_q    <= {opcode, op};
        illegal_q <= 1'b0;
      end
      if (set_illegal) illegal_q <= 1'b1;
      if (retire) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w     = 1'b0;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    vsel  = VSEL_C;
    nsel  = NSEL_RN;
    write = 1'b0;
    case (state_q)
      ST_WAIT:  w = 1'b1;
      ST_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      ST_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      ST_EXEC: begin
        loadc = 1'b1;
        asel  = is_b_only(insn_q);
        loads = is_cmp(insn_q);
      end
      ST_WR_REG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      ST_WR_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM8;
        write = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal    = illegal_q;
  assign insn_count = cnt_q;

endmodule
